bram1_arbiter: RTL and testbench
================================

BRAM1_ARBITER -- requirements
Module: bram1_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 1, the BRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 1, the BRAM data width.
REQ-003 SHALL have parameter PIPELINED, default 0, the BRAM read latency select: 0 gives 1 cycle, 1 gives 2 cycles.
REQ-004 SHALL have port CLK  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have, for each client n in {0,1}, REQn_VALID  input  1  request present.
REQ-007 SHALL have REQn_READY  output  1  request accepted this cycle when high together with REQn_VALID.
REQ-008 SHALL have REQn_WE  input  1  1 = write, 0 = read.
REQ-009 SHALL have REQn_ADDR  input  ADDR_WIDTH  request address.
REQ-010 SHALL have REQn_DI  input  DATA_WIDTH  write data.
REQ-011 SHALL have RSPn_VALID  output  1  read data available.
REQ-012 SHALL have RSPn_READY  input  1  client consumes the response.
REQ-013 SHALL have RSPn_DO  output  DATA_WIDTH  read data.
REQ-014 SHALL have BRAM_EN, BRAM_WE  output  1 each  single-port BRAM controls.
REQ-015 SHALL have BRAM_ADDR  output  ADDR_WIDTH, and BRAM_DI  output  DATA_WIDTH.
REQ-016 SHALL have BRAM_DO  input  DATA_WIDTH  BRAM read data.

Function
REQ-017 SHALL grant at most one request per cycle; BRAM_EN/WE/ADDR/DI are combinational from the granted request, and BRAM_EN=0 when nothing is granted.
REQ-018 SHALL treat client n as eligible when REQn_VALID=1 and either REQn_WE=1 or read credit n > 0.
REQ-019 SHALL keep read credit n = 2 - (reads for n in flight + entries in RSP buffer n), range 0..2.
REQ-020 SHALL arbitrate round-robin by default: the pointer names the favoured client; when both are eligible the favoured client wins; after any grant the pointer moves to the other client.
REQ-021 SHALL raise REQn_READY only for the granted client.
REQ-022 SHALL track in-flight reads with a tag shift pipeline (valid, client id) of depth 1+PIPELINED.
REQ-023 SHALL capture BRAM_DO into RSP buffer n in the cycle the tag exits the pipeline: exactly 1+PIPELINED cycles after the grant.
REQ-024 SHALL use a 2-entry FIFO per client for the RSP buffer, with RSPn_VALID = not empty and RSPn_DO = head; the credit rule guarantees no overflow, so the capture is never dropped.
REQ-025 SHALL issue a write with no response; the write is complete in the grant cycle.
REQ-026 SHALL allow a simultaneous push and pop on the same RSP FIFO, including when it is full, with FIFO order preserved.
REQ-027 SHALL allow a credit returned by a pop to be used for a grant in the following cycle, not the same cycle.
REQ-028 SHALL return responses per client in request order.
REQ-029 SHALL not create ordering between clients.

Reset
REQ-030 SHALL, while RST=1, clear all tags, empty both FIFOs, set both credits to 2, and set the pointer to client 0.
REQ-031 SHALL hold REQn_READY=0, RSPn_VALID=0 and BRAM_EN=0 while RST=1.
REQ-032 SHALL discard reads in flight when reset is asserted mid-operation; no response is produced for them after reset.

Configuration
REQ-033 SHALL honour macro BRAM1_ARB_FIXED_PRIO_EN: when defined, client 0 always wins when both are eligible and the pointer is unused; when undefined, round-robin per REQ-020 applies.

Verification
REQ-034 SHALL cover: PIPELINED=0; client 0 writes addr 3 = 0xA5; then client 0 reads addr 3 -> RSP0_VALID with RSP0_DO=0xA5 one cycle after the read grant.
REQ-035 SHALL cover: both clients hold read requests continuously with RSP ready=1 -> grants alternate 0,1,0,1 starting with client 0 after reset (without the macro).
REQ-036 SHALL cover: client 1 issues 3 reads with RSP1_READY=0 -> only 2 granted and REQ1_READY stays 0; raise RSP1_READY for one cycle -> the 3rd read is granted the next cycle.
REQ-037 SHALL cover: PIPELINED=1; client 0 reads addr 7 (=0x3C) at cycle t -> RSP0_DO=0x3C valid at t+2.
REQ-038 SHALL cover: RST asserted one cycle after a read grant -> no RSP valid after reset, and credits=2.
REQ-039 SHALL cover: with the macro defined, both clients request continuously -> client 0 always granted and client 1 never granted.

Source files
------------

// File: rtl/bram1_arbiter.sv
// -----------------------------------------------------------------------------
// bram1_arbiter
//
// Shares one single-port BRAM between two request/response clients.
// At most one request is granted per cycle. Writes complete in the grant
// cycle and produce no response. Reads are tracked by a tag pipeline that
// matches the BRAM read latency (1 + PIPELINED cycles). When a tag leaves the
// pipeline, BRAM_DO is captured into that client's 2-entry response FIFO.
//
// Each client has a read credit of 2 minus its reads in flight minus its
// buffered responses. A read is only eligible while credit is non-zero, so a
// capture always finds room in the FIFO. Credit is computed from registered
// state only. As a result, a slot freed by a pop can be granted the next cycle
// at the earliest.
//
// Arbitration is round-robin: the pointer names the favoured client and flips
// to the other client after every grant. If BRAM1_ARB_FIXED_PRIO_EN is defined,
// client 0 always wins a tie instead, and the pointer is not built.
//
// Parameters
//   ADDR_WIDTH  BRAM address width
//   DATA_WIDTH  BRAM data width
//   PIPELINED   0: 1-cycle BRAM read latency, 1: 2-cycle
//
// Ports
//   CLK, RST               clock; synchronous active-high reset
//   REQn_VALID/READY       request handshake, client n in {0,1}
//   REQn_WE/ADDR/DI        request: 1 = write, address, write data
//   RSPn_VALID/READY/DO    read response handshake and data (FIFO head)
//   BRAM_EN/WE/ADDR/DI     BRAM controls, combinational from the granted request
//   BRAM_DO                BRAM read data
//
// Compile-time option: BRAM1_ARB_FIXED_PRIO_EN (fixed priority, client 0 wins)
// -----------------------------------------------------------------------------
module bram1_arbiter #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int PIPELINED  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,

  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic                  REQ0_WE,
  input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ0_DI,
  output logic                  RSP0_VALID,
  input  logic                  RSP0_READY,
  output logic [DATA_WIDTH-1:0] RSP0_DO,

  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic                  REQ1_WE,
  input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ1_DI,
  output logic                  RSP1_VALID,
  input  logic                  RSP1_READY,
  output logic [DATA_WIDTH-1:0] RSP1_DO,

  output logic                  BRAM_EN,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  localparam int DEPTH = 1 + PIPELINED;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  // Client signals gathered into arrays so both clients share one description.
  logic [1:0]            req_valid;
  logic [1:0]            req_we;
  logic [1:0]            rsp_ready;
  logic [1:0]            rsp_valid;
  logic [ADDR_WIDTH-1:0] req_addr   [2];
  logic [DATA_WIDTH-1:0] req_di     [2];
  logic [DATA_WIDTH-1:0] rsp_do     [2];
  logic [1:0]            fifo_count [2];
  logic [1:0]            inflight   [2];
  logic [1:0]            credit     [2];
  logic [1:0]            elig;
  logic                  any_gnt;
  logic                  gnt_id;
  tag_t                  tag_q      [DEPTH];
  tag_t                  tag_out;

  assign req_valid   = {REQ1_VALID, REQ0_VALID};
  assign req_we      = {REQ1_WE, REQ0_WE};
  assign rsp_ready   = {RSP1_READY, RSP0_READY};
  assign req_addr[0] = REQ0_ADDR;
  assign req_addr[1] = REQ1_ADDR;
  assign req_di[0]   = REQ0_DI;
  assign req_di[1]   = REQ1_DI;

  // Count the reads in flight for each client.
  // NOTE: every output of a combinational block gets a default value first.
  // Without it, a path that skips an assignment infers a latch.
  always_comb begin
    inflight[0] = '0;
    inflight[1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int n = 0; n < 2; n++) begin
        inflight[n] = inflight[n] +
                      ((tag_q[i].vld && (tag_q[i].id == 1'(n))) ? 2'd1 : 2'd0);
      end
    end
  end

  // A write is always eligible. A read needs a free response slot.
  // Reset masks every grant.
  for (genvar n = 0; n < 2; n++) begin : g_elig
    assign credit[n] = 2'd2 - inflight[n] - fifo_count[n];
    assign elig[n]   = req_valid[n] & (req_we[n] | (credit[n] != 2'd0)) & ~RST;
  end

  assign any_gnt = |elig;

`ifdef BRAM1_ARB_FIXED_PRIO_EN
  // Client 0 wins whenever it is eligible.
  assign gnt_id = ~elig[0];
`else
  // Round-robin pointer: names the client favoured on a tie.
  logic rr_ptr;

  assign gnt_id = (&elig) ? rr_ptr : elig[1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= 1'b0;
    end else if (any_gnt) begin
      rr_ptr <= ~gnt_id;
    end
  end
`endif

  assign REQ0_READY = any_gnt & ~gnt_id;
  assign REQ1_READY = any_gnt &  gnt_id;

  assign BRAM_EN   = any_gnt;
  assign BRAM_WE   = any_gnt & req_we[gnt_id];
  assign BRAM_ADDR = req_addr[gnt_id];
  assign BRAM_DI   = req_di[gnt_id];

  // Tag pipeline. It mirrors the BRAM read latency, so the last stage names
  // the client whose data is on BRAM_DO this cycle.
  // NOTE: state registers use non-blocking assignments. Each stage then takes
  // the value its predecessor held before the edge, not the one just written.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_t'{vld: any_gnt & ~req_we[gnt_id], id: gnt_id};
      for (int i = 1; i < DEPTH; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[DEPTH-1];

  // Per-client 2-entry response FIFOs.
  for (genvar n = 0; n < 2; n++) begin : g_rsp
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  push;
    logic                  pop;

    assign push = tag_out.vld && (tag_out.id == 1'(n)) && !RST;
    assign pop  = rsp_valid[n] && rsp_ready[n];

    always_ff @(posedge CLK) begin
      if (RST) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end

    // When the FIFO is full, wr_ptr equals rd_ptr. A push with a pop in the
    // same cycle then overwrites the slot being popped, and the new data
    // lands behind the remaining entry, so order is kept.
    // NOTE: the storage has no reset. The count qualifies every entry,
    // so the stale contents after reset are never observed.
    always_ff @(posedge CLK) begin
      if (push) begin
        mem[wr_ptr] <= BRAM_DO;
      end
    end

    assign fifo_count[n] = count;
    assign rsp_valid[n]  = (count != 2'd0) && !RST;
    assign rsp_do[n]     = mem[rd_ptr];
  end

  assign RSP0_VALID = rsp_valid[0];
  assign RSP1_VALID = rsp_valid[1];
  assign RSP0_DO    = rsp_do[0];
  assign RSP1_DO    = rsp_do[1];

endmodule

// File: tb/tb_bram1_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram1_arbiter
//
// dut0: PIPELINED=0. Its BRAM model has 1-cycle registered read data.
// dut1: PIPELINED=1. Its BRAM model has 2-cycle read data.
//
// Both BRAM models reload on reset: mem[a] = 0x10 + a, except mem[7] = 0x3C.
//
// When a read handshake is seen, the stimulus side pushes the hand-computed
// data into a per-client queue. It also pushes the cycle in which the response
// must first be visible. A monitor pops and compares on every response
// handshake. A second monitor checks the grant order against an expected list.
//
// Timing convention: inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge. If a handshake is seen at falling edge c, the
// request is taken at edge c+1. The data is captured 1 + PIPELINED cycles
// later, so the response is visible at falling edge c + 2 + PIPELINED.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bram1_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
    bit            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- dut0 (PIPELINED = 0) ----------------
  logic [1:0]    rv, rw, sr;
  logic [AW-1:0] ra [2];
  logic [DW-1:0] rd [2];
  logic          r0_ready, r1_ready, s0_valid, s1_valid;
  logic [DW-1:0] s0_do, s1_do;
  logic [1:0]    rr, sv;
  logic          b_en, b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_di, b_do;
  logic [DW-1:0] mem0 [16];

  assign rr = {r1_ready, r0_ready};
  assign sv = {s1_valid, s0_valid};

  bram1_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(0)) dut0 (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(rv[0]), .REQ0_READY(r0_ready), .REQ0_WE(rw[0]),
    .REQ0_ADDR(ra[0]), .REQ0_DI(rd[0]),
    .RSP0_VALID(s0_valid), .RSP0_READY(sr[0]), .RSP0_DO(s0_do),
    .REQ1_VALID(rv[1]), .REQ1_READY(r1_ready), .REQ1_WE(rw[1]),
    .REQ1_ADDR(ra[1]), .REQ1_DI(rd[1]),
    .RSP1_VALID(s1_valid), .RSP1_READY(sr[1]), .RSP1_DO(s1_do),
    .BRAM_EN(b_en), .BRAM_WE(b_we), .BRAM_ADDR(b_addr), .BRAM_DI(b_di),
    .BRAM_DO(b_do)
  );

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem0[i] <= 8'h10 + 8'(i);
      mem0[7] <= 8'h3C;
    end else if (b_en) begin
      if (b_we) mem0[b_addr] <= b_di;
      else      b_do <= mem0[b_addr];
    end
  end

  // ---------------- dut1 (PIPELINED = 1), client 0 only ----------------
  logic          pv, pw, pr, ps_valid, p1_ready, p1_valid;
  logic [AW-1:0] pa;
  logic [DW-1:0] pd, ps_do, p1_do;
  logic          pb_en, pb_we;
  logic [AW-1:0] pb_addr;
  logic [DW-1:0] pb_di, pb_stage, pb_do;
  logic [DW-1:0] mem1 [16];

  bram1_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(1)) dut1 (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(pv), .REQ0_READY(pr), .REQ0_WE(pw),
    .REQ0_ADDR(pa), .REQ0_DI(pd),
    .RSP0_VALID(ps_valid), .RSP0_READY(1'b1), .RSP0_DO(ps_do),
    .REQ1_VALID(1'b0), .REQ1_READY(p1_ready), .REQ1_WE(1'b0),
    .REQ1_ADDR(4'h0), .REQ1_DI(8'h00),
    .RSP1_VALID(p1_valid), .RSP1_READY(1'b1), .RSP1_DO(p1_do),
    .BRAM_EN(pb_en), .BRAM_WE(pb_we), .BRAM_ADDR(pb_addr), .BRAM_DI(pb_di),
    .BRAM_DO(pb_do)
  );

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem1[i] <= 8'h10 + 8'(i);
      mem1[7] <= 8'h3C;
    end else if (pb_en) begin
      if (pb_we) mem1[pb_addr] <= pb_di;
      else       pb_stage <= mem1[pb_addr];
    end
    pb_do <= pb_stage;
  end

  // ---------------- scoreboard ----------------
  exp_t          q0[$], q1[$], qp[$];
  int            gq[$];
  bit            gnt_chk = 1'b0;
  bit            lat_on  = 1'b1;
  logic [DW-1:0] e0, e1, ep;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_rsp(input string name, input exp_t it, input logic [DW-1:0] d);
    check({name, "_data"}, 32'(d), 32'(it.d));
    if (it.lat) check({name, "_cycle"}, cyc, it.due);
  endtask

  // Stimulus side: record the expected response for every accepted read.
  always @(negedge clk) begin
    if (!rst) begin
      if (rv[0] && r0_ready && !rw[0]) q0.push_back(exp_t'{d: e0, due: cyc + 2, lat: lat_on});
      if (rv[1] && r1_ready && !rw[1]) q1.push_back(exp_t'{d: e1, due: cyc + 2, lat: lat_on});
      if (pv && pr && !pw)             qp.push_back(exp_t'{d: ep, due: cyc + 3, lat: 1'b1});
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_t it;
    if (!rst) begin
      if (s0_valid && sr[0]) begin
        if (q0.size() == 0) check("rsp0_unexpected", 1, 0);
        else begin it = q0.pop_front(); cmp_rsp("rsp0", it, s0_do); end
      end
      if (s1_valid && sr[1]) begin
        if (q1.size() == 0) check("rsp1_unexpected", 1, 0);
        else begin it = q1.pop_front(); cmp_rsp("rsp1", it, s1_do); end
      end
      if (ps_valid) begin
        if (qp.size() == 0) check("prsp0_unexpected", 1, 0);
        else begin it = qp.pop_front(); cmp_rsp("prsp0", it, ps_do); end
      end
      if (p1_valid) check("prsp1_unexpected", 1, 0);
    end
  end

  // Grant-order monitor.
  always @(negedge clk) begin
    if (!rst && gnt_chk && (|rr)) begin
      check("grant_onehot", 32'(rr == 2'b11), 0);
      if (gq.size() == 0) check("grant_extra", 32'(rr), 0);
      else                check("grant_client", 32'(rr[1]), gq.pop_front());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int c);
    return (c == 2) ? pr : rr[c[0]];
  endfunction

  // Returns at the falling edge where the handshake is visible.
  task automatic wait_hs(input int c, input string name);
    int n = 0;
    @(negedge clk);
    while (!rdy(c) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(c)) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete(); qp.delete();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int gcnt;
    int n;
    rv = '0; rw = '0; sr = 2'b11;
    ra[0] = '0; ra[1] = '0; rd[0] = '0; rd[1] = '0;
    e0 = '0; e1 = '0; ep = '0;
    pv = 1'b0; pw = 1'b0; pa = '0; pd = '0;

    // Requests presented during reset must not be granted.
    repeat (2) tick();
    rv = 2'b11; pv = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(rr), 0);
    check("rst_bram_en", 32'(b_en), 0);
    check("rst_rsp_valid", 32'(sv), 0);
    check("rst_p_ready", 32'(pr), 0);
    check("rst_p_bram_en", 32'(pb_en), 0);
    tick();
    rv = '0; pv = 1'b0; rst = 1'b0;

    // Client 0 writes 0xA5 to addr 3, then reads it back.
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 4'd3; rd[0] = 8'hA5;
    wait_hs(0, "wr0");
    check("wr_bram_en", 32'(b_en), 1);
    check("wr_bram_we", 32'(b_we), 1);
    check("wr_bram_addr", 32'(b_addr), 3);
    check("wr_bram_di", 32'(b_di), 32'hA5);
    tick();
    rw[0] = 1'b0; e0 = 8'hA5;
    wait_hs(0, "rd0");
    check("rd_bram_en_we", 32'({b_en, b_we}), 2);
    check("rd_bram_addr", 32'(b_addr), 3);
    tick();
    rv[0] = 1'b0;
    repeat (4) tick();
    check("rd0_drained", q0.size(), 0);

    // Both clients request continuously from reset.
    do_reset();
`ifdef BRAM1_ARB_FIXED_PRIO_EN
    rw = 2'b11; ra[0] = 4'd8; ra[1] = 4'd9; rd[0] = 8'h01; rd[1] = 8'h02;
    for (int i = 0; i < 6; i++) gq.push_back(0);
`else
    rw = 2'b00; ra[0] = 4'd1; ra[1] = 4'd2; e0 = 8'h11; e1 = 8'h12;
    for (int i = 0; i < 6; i++) gq.push_back(i % 2);
`endif
    gnt_chk = 1'b1;
    rv = 2'b11;
    n = 0;
    while (gq.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    rv = '0; rw = '0; gnt_chk = 1'b0;
    check("alt_grants_left", gq.size(), 0);
    repeat (5) tick();
    check("alt_q0_drained", q0.size(), 0);
    check("alt_q1_drained", q1.size(), 0);

    // Client 1 credit limit: with responses stalled, only two reads are taken.
    sr[1] = 1'b0; lat_on = 1'b0;
    rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 4'd5; e1 = 8'h15;
    gcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (r1_ready) gcnt++;
    end
    check("cr1_grants", gcnt, 2);
    check("cr1_ready_low", 32'(r1_ready), 0);
    tick();
    sr[1] = 1'b1;                       // one pop this cycle
    @(negedge clk);
    check("cr1_same_cycle", 32'(r1_ready), 0);
    tick();
    sr[1] = 1'b0;
    @(negedge clk);
    check("cr1_next_cycle", 32'(r1_ready), 1);
    tick();
    rv[1] = 1'b0; sr[1] = 1'b1;
    repeat (6) tick();
    check("cr1_drained", q1.size(), 0);
    lat_on = 1'b1;

    // Reset one cycle after a read grant: the read is discarded.
    rv[0] = 1'b1; ra[0] = 4'd4; e0 = 8'h14;
    wait_hs(0, "rst_rd");
    tick();
    rv[0] = 1'b0;
    rst = 1'b1;
    q0.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_rsp", 32'(sv), 0);
    end
    tick();
    sr[0] = 1'b0; lat_on = 1'b0;
    rv[0] = 1'b1; ra[0] = 4'd4; e0 = 8'h14;
    gcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (r0_ready) gcnt++;
    end
    check("cr0_after_rst", gcnt, 2);
    tick();
    rv[0] = 1'b0; sr[0] = 1'b1;
    repeat (5) tick();
    check("cr0_drained", q0.size(), 0);
    lat_on = 1'b1;

    // PIPELINED=1: read addr 7 (0x3C), then addr 3 (0x13), back to back.
    pv = 1'b1; pw = 1'b0; pa = 4'd7; ep = 8'h3C;
    wait_hs(2, "p_rd7");
    tick();
    pa = 4'd3; ep = 8'h13;
    wait_hs(2, "p_rd3");
    tick();
    pv = 1'b0;
    repeat (6) tick();
    check("p_drained", qp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
